// File: rtl/slurmboy_uart_pkg.sv
//------------------------------------------------------------------------------
// Module  : slurmboy_uart_pkg
// Purpose : Shared UART register map, STATUS bit indices and RX FSM states.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package slurmboy_uart_pkg;

  localparam logic [1:0] UART_REG_DATA   = 2'd0;
  localparam logic [1:0] UART_REG_STATUS = 2'd1;

  localparam int STAT_OVR  = 0;
  localparam int STAT_FERR = 1;
  localparam int STAT_PERR = 2;

  typedef enum logic [2:0] {
    ST_WAIT_IDLE = 3'd0,
    ST_IDLE      = 3'd1,
    ST_START     = 3'd2,
    ST_DATA      = 3'd3,
`ifdef UART_RX_PARITY_EN
    ST_PARITY    = 3'd4,
`endif
    ST_STOP      = 3'd5
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
//------------------------------------------------------------------------------
// Module  : uart_rx_fifo
// Purpose : Synchronous FIFO with wrap-bit pointers; a push while full only
//           lands when a pop happens in the same cycle.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_wr_en;
  logic             w_rd_en;

  assign empty    = (r_wr_ptr == r_rd_ptr);
  assign full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign count    = r_wr_ptr - r_rd_ptr;
  assign pop_data = r_mem[r_rd_ptr[AW-1:0]];
  assign w_rd_en  = pop & ~empty;
  assign w_wr_en  = push & (~full | w_rd_en);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_axi.sv
//------------------------------------------------------------------------------
// Module  : uart_rx_axi
// Purpose : UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) feeding a FIFO
//           read through an AXI4-lite register interface.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx_axi #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        uart_rx,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_awaddr,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  input  logic [31:0] s_axi_araddr,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [31:0] s_axi_rdata,
  output logic        rx_irq
);

  import slurmboy_uart_pkg::*;

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);
  localparam int AW           = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] c_bit_last  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] c_half_last = CW'(CLKS_PER_BIT / 2 - 1);

  logic r_rx_meta, r_rx_sync;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= uart_rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  rx_state_t     r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [2:0]    r_bit_idx, w_bit_idx_next;
  logic [7:0]    r_shift, w_shift_next;
  logic          r_par_bad, w_par_bad_next;
  logic          w_bit_tick, w_push, w_ferr_set, w_perr_set;

  assign w_bit_tick = (r_cnt == c_bit_last);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= ST_WAIT_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_par_bad <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_par_bad <= w_par_bad_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt + CW'(1);
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_par_bad_next = r_par_bad;
    w_push         = 1'b0;
    w_ferr_set     = 1'b0;
    w_perr_set     = 1'b0;
    case (r_state)
      // A full bit time of idle line is required before trusting a falling edge.
      ST_WAIT_IDLE: begin
        if (!r_rx_sync) begin
          w_cnt_next = '0;
        end else if (w_bit_tick) begin
          w_cnt_next   = '0;
          w_state_next = ST_IDLE;
        end
      end
      ST_IDLE: begin
        w_cnt_next = '0;
        if (!r_rx_sync) w_state_next = ST_START;
      end
      ST_START: begin
        if (r_cnt == c_half_last) begin
          w_cnt_next     = '0;
          w_bit_idx_next = '0;
          w_par_bad_next = 1'b0;
          w_state_next   = r_rx_sync ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_bit_tick) begin
          w_cnt_next     = '0;
          w_shift_next   = {r_rx_sync, r_shift[7:1]};
          w_bit_idx_next = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_next = ST_PARITY;
`else
            w_state_next = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (w_bit_tick) begin
          w_cnt_next     = '0;
          w_par_bad_next = (r_rx_sync != ^r_shift);
          w_state_next   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (w_bit_tick) begin
          w_cnt_next = '0;
          w_perr_set = r_par_bad;
          if (r_rx_sync) begin
            w_push       = ~r_par_bad;
            w_state_next = ST_IDLE;
          end else begin
            w_ferr_set   = 1'b1;
            w_state_next = ST_WAIT_IDLE;
          end
        end
      end
      default: w_state_next = ST_WAIT_IDLE;
    endcase
  end

  logic        w_full, w_empty, w_pop;
  logic [7:0]  w_pop_data;
  logic [AW:0] w_count;
  logic [8:0]  w_count_ext;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (w_push),
    .push_data (r_shift),
    .pop       (w_pop),
    .pop_data  (w_pop_data),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  assign w_count_ext = 9'(w_count);

  logic        r_rvalid, r_arready, r_bvalid;
  logic [31:0] r_rdata, w_rd_word;
  logic        w_ar_hs, w_aw_hs, w_rvalid_next;
  logic [2:0]  w_clr;
  logic        r_ovr, r_ferr, r_perr;

  assign w_ar_hs       = s_axi_arvalid & r_arready;
  assign w_aw_hs       = s_axi_awvalid & s_axi_wvalid & ~r_bvalid;
  assign w_pop         = w_ar_hs & (s_axi_araddr[3:2] == UART_REG_DATA) & ~w_empty;
  assign w_rvalid_next = w_ar_hs | (r_rvalid & ~s_axi_rready);

  always_comb begin
    w_rd_word = '0;
    case (s_axi_araddr[3:2])
      UART_REG_DATA:   if (!w_empty) w_rd_word = {23'b0, 1'b1, w_pop_data};
      UART_REG_STATUS: w_rd_word = {16'b0, w_count_ext[7:0], 5'b0, r_perr, r_ferr, r_ovr};
      default:         w_rd_word = '0;
    endcase
  end

  always_comb begin
    w_clr = '0;
    if (w_aw_hs && s_axi_awaddr[3:2] == UART_REG_STATUS) w_clr = s_axi_wdata[2:0];
`ifndef UART_RX_PARITY_EN
    w_clr[STAT_PERR] = 1'b0;
`endif
  end

  // Sticky flags: a set in the same cycle as a W1C clear takes priority.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ovr  <= 1'b0;
      r_ferr <= 1'b0;
      r_perr <= 1'b0;
    end else begin
      r_ovr  <= (w_push & w_full & ~w_pop) | (r_ovr & ~w_clr[STAT_OVR]);
      r_ferr <= w_ferr_set | (r_ferr & ~w_clr[STAT_FERR]);
      r_perr <= w_perr_set | (r_perr & ~w_clr[STAT_PERR]);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rvalid  <= 1'b0;
      r_arready <= 1'b0;
      r_rdata   <= '0;
      r_bvalid  <= 1'b0;
    end else begin
      r_rvalid  <= w_rvalid_next;
      r_arready <= ~w_rvalid_next;
      if (w_ar_hs) r_rdata <= w_rd_word;
      r_bvalid  <= w_aw_hs | (r_bvalid & ~s_axi_bready);
    end
  end

  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_awready = w_aw_hs;
  assign s_axi_wready  = w_aw_hs;
  assign s_axi_bvalid  = r_bvalid;
  assign rx_irq        = ~w_empty | r_ovr | r_ferr | r_perr;

  logic w_unused;
  assign w_unused = ^{s_axi_awaddr[31:4], s_axi_awaddr[1:0], s_axi_araddr[31:4],
                      s_axi_araddr[1:0], s_axi_wstrb, s_axi_wdata[31:3], w_count_ext[8]};

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_axi.sv
//------------------------------------------------------------------------------
// Module  : tb_uart_rx_axi
// Purpose : Self-checking bench for uart_rx_axi at 10 clocks per bit.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx_axi;

  localparam int CPB = 10;
  localparam int TMO = 50;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        uart_rx = 1'b1;
  logic        s_axi_awvalid = 1'b0, s_axi_wvalid = 1'b0, s_axi_bready = 1'b1;
  logic        s_axi_arvalid = 1'b0, s_axi_rready = 1'b1;
  logic [31:0] s_axi_awaddr = '0, s_axi_wdata = '0, s_axi_araddr = '0;
  logic [3:0]  s_axi_wstrb = 4'hF;
  logic        s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, rx_irq;
  logic [31:0] s_axi_rdata;

  always #5 CLK = ~CLK;

  uart_rx_axi #(
    .CLK_FREQ   (1_000_000),
    .BAUD       (100_000),
    .FIFO_DEPTH (16)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .uart_rx       (uart_rx),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .s_axi_rdata   (s_axi_rdata),
    .rx_irq        (rx_irq)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  m_fifo[$];
  logic        m_ovr = 1'b0, m_ferr = 1'b0, m_perr = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rdata = '0;
  logic        busy = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out after %0d cycles", name, TMO);
  endtask

  // Reference model: an ideal byte queue plus three sticky flags.
  function automatic logic [31:0] model_read(input logic [1:0] sel);
    logic [7:0] b;
    if (sel == 2'd0) begin
      if (m_fifo.size() == 0) return 32'h0;
      b = m_fifo.pop_front();
      return {23'b0, 1'b1, b};
    end
    if (sel == 2'd1) return {16'b0, 8'(m_fifo.size()), 5'b0, m_perr, m_ferr, m_ovr};
    return 32'h0;
  endfunction

  function automatic void model_frame(input logic [7:0] b, input logic stop_ok);
    if (!stop_ok)               m_ferr = 1'b1;
    else if (m_fifo.size() >= 16) m_ovr = 1'b1;
    else                        m_fifo.push_back(b);
  endfunction

  function automatic void model_reset();
    m_fifo.delete();
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    m_perr = 1'b0;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // rst_bit >= 0 pulses RST part-way through that data bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_ok, input int rst_bit);
    busy    = 1'b1;
    uart_rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      if (i == rst_bit) begin
        repeat (3) tick();
        RST = 1'b1;
        repeat (2) tick();
        RST = 1'b0;
        model_reset();
        repeat (CPB - 5) tick();
      end else begin
        repeat (CPB) tick();
      end
    end
    uart_rx = stop_ok;
    repeat (CPB) tick();
    uart_rx = 1'b1;
    repeat (2 * CPB) tick();
    if (rst_bit < 0) model_frame(b, stop_ok);
    busy = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input int hold);
    int t;
    busy = 1'b1;
    exp_q.push_back(model_read(addr[3:2]));
    s_axi_araddr  = addr;
    s_axi_arvalid = 1'b1;
    s_axi_rready  = (hold == 0);
    t = 0;
    while (!s_axi_arready && t < TMO) begin tick(); t++; end
    if (t >= TMO) timeout_fail("arready");
    tick();
    s_axi_arvalid = 1'b0;
    if (hold > 0) begin
      repeat (hold) tick();
      s_axi_rready = 1'b1;
    end
    t = 0;
    while (!s_axi_rvalid && t < TMO) begin tick(); t++; end
    if (t >= TMO) timeout_fail("rvalid");
    last_rdata = s_axi_rdata;
    tick();
    busy = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data);
    int t;
    busy = 1'b1;
    if (addr[3:2] == 2'd1) begin
      if (data[0]) m_ovr  = 1'b0;
      if (data[1]) m_ferr = 1'b0;
    end
    s_axi_awaddr  = addr;
    s_axi_wdata   = data;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    t = 0;
    while (!(s_axi_awready && s_axi_wready) && t < TMO) begin tick(); t++; end
    if (t >= TMO) timeout_fail("awready");
    tick();
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    t = 0;
    while (!s_axi_bvalid && t < TMO) begin tick(); t++; end
    check("bvalid", s_axi_bvalid, 1'b1);
    tick();
    busy = 1'b0;
  endtask

  // Per-cycle comparison against the model and AXI hold rules.
  logic        prev_wait = 1'b0;
  logic [31:0] prev_rdata = '0;

  always @(negedge CLK) begin
    if (RST) begin
      prev_wait = 1'b0;
    end else begin
      if (prev_wait) begin
        check("rvalid_hold", s_axi_rvalid, 1'b1);
        check("rdata_hold", s_axi_rdata, prev_rdata);
      end
      if (s_axi_rvalid) check("arready_while_rvalid", s_axi_arready, 1'b0);
      if (s_axi_rvalid && s_axi_rready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rdata_unexpected: got 0x%08h, expected no response", s_axi_rdata);
        end else begin
          check("rdata", s_axi_rdata, exp_q.pop_front());
        end
      end
      if (!busy) check("rx_irq", rx_irq, (m_fifo.size() != 0) | m_ovr | m_ferr | m_perr);
      prev_wait  = s_axi_rvalid & ~s_axi_rready;
      prev_rdata = s_axi_rdata;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    check("rst_arready", s_axi_arready, 1'b0);
    check("rst_rvalid", s_axi_rvalid, 1'b0);
    check("rst_rdata", s_axi_rdata, 32'h0);
    check("rst_bvalid", s_axi_bvalid, 1'b0);
    check("rst_awready", s_axi_awready, 1'b0);
    check("rst_irq", rx_irq, 1'b0);
    RST = 1'b0;
    repeat (2 * CPB) tick();
    check("arready_after_rst", s_axi_arready, 1'b1);
    busy = 1'b0;

    // single byte
    send_frame(8'hA5, 1'b1, -1);
    axi_read(32'h0, 0);  check("lit_a5", last_rdata, 32'h0000_01A5);
    axi_read(32'h4, 0);  check("lit_status0", last_rdata, 32'h0);
    axi_read(32'h0, 0);  check("lit_empty", last_rdata, 32'h0);
    axi_write(32'h0, 32'hFFFF_FFFF);
    axi_write(32'h8, 32'h1234_5678);
    axi_read(32'h8, 0);  check("lit_reg8", last_rdata, 32'h0);
    axi_read(32'hC, 0);  check("lit_regC", last_rdata, 32'h0);

    // overflow
    for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1, -1);
    axi_read(32'h4, 0);  check("lit_full_status", last_rdata, 32'h0000_1001);
    for (int i = 0; i < 16; i++) axi_read(32'h0, 0);
    check("lit_last_byte", last_rdata, 32'h0000_010F);
    axi_read(32'h0, 0);  check("lit_drained", last_rdata, 32'h0);
    axi_read(32'h4, 0);  check("lit_ovr_only", last_rdata, 32'h0000_0001);
    axi_write(32'h4, 32'h1);
    axi_read(32'h4, 0);  check("lit_ovr_clr", last_rdata, 32'h0);

    // framing error
    send_frame(8'h3C, 1'b0, -1);
    check("lit_ferr_irq", rx_irq, 1'b1);
    axi_read(32'h4, 0);  check("lit_ferr", last_rdata, 32'h0000_0002);
    axi_write(32'h4, 32'h2);
    tick();
    check("lit_ferr_irq_clr", rx_irq, 1'b0);
    axi_read(32'h0, 0);  check("lit_ferr_nobyte", last_rdata, 32'h0);
    axi_write(32'h4, 32'h7);
    axi_read(32'h4, 0);  check("lit_perr_absent", last_rdata, 32'h0);

    // short glitch on idle line
    busy = 1'b1;
    uart_rx = 1'b0;
    repeat (3) tick();
    uart_rx = 1'b1;
    repeat (3 * CPB) tick();
    busy = 1'b0;
    axi_read(32'h4, 0);  check("lit_glitch", last_rdata, 32'h0);
    send_frame(8'hC3, 1'b1, -1);
    axi_read(32'h0, 0);  check("lit_after_glitch", last_rdata, 32'h0000_01C3);

    // reset mid-frame
    send_frame(8'h0F, 1'b1, 4);
    axi_read(32'h4, 0);  check("lit_after_rst", last_rdata, 32'h0);
    send_frame(8'h55, 1'b1, -1);
    axi_read(32'h4, 0);  check("lit_count1", last_rdata, 32'h0000_0100);
    axi_read(32'h0, 0);  check("lit_55", last_rdata, 32'h0000_0155);

    // rready held low
    send_frame(8'h81, 1'b1, -1);
    axi_read(32'h0, 5);  check("lit_hold", last_rdata, 32'h0000_0181);
    repeat (5) tick();
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL pending_reads: got %0d outstanding, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
